// File: rtl/palt_nios_timer_host.sv
// rtl/palt_nios_timer_host.sv - Avalon-MM host that programs an interval timer and services its timeouts
module palt_nios_timer_host #(
   parameter int         TICK_W    = 32,
   parameter logic [3:0] CTRL_INIT = 4'b0111
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop_req,
   input  logic              irq,
   input  logic [15:0]       readdata,
   output logic [2:0]        address,
   output logic              chipselect,
   output logic              write_n,
   output logic [15:0]       writedata,
   output logic              running,
   output logic              tick_pulse,
   output logic [TICK_W-1:0] tick_count,
   output logic              err_spurious
);

   typedef enum logic [2:0] {
      IDLE, INIT_WR, RUN, RD_STAT, RD_WAIT, CLR_WR, STOP_WR
   } state_t;

   // Timer register map: status at 0 (bit 0 = TO), control at 1 (bit 3 = STOP).
   localparam logic [2:0]  ADDR_STATUS = 3'd0;
   localparam logic [2:0]  ADDR_CTRL   = 3'd1;
   localparam logic [15:0] CTRL_STOP   = 16'h0008;

   state_t              state_q, state_d;
   logic                running_q, running_d;
   logic                stop_pend_q, stop_pend_d;
   logic                tick_pulse_q, tick_pulse_d;
   logic                err_spurious_q, err_spurious_d;
   logic [TICK_W-1:0]   tick_count_q, tick_count_d;

   // Only the TO bit of the status word matters to this host.
   logic unused_rd_bits;
   assign unused_rd_bits = ^readdata[15:1];

   // Next-state, bookkeeping updates and Moore-decoded bus signals.
   always_comb begin
      state_d        = state_q;
      running_d      = running_q;
      stop_pend_d    = stop_pend_q;
      tick_pulse_d   = 1'b0;
      err_spurious_d = 1'b0;
      tick_count_d   = tick_count_q;
      chipselect     = 1'b0;
      write_n        = 1'b1;
      address        = 3'd0;
      writedata      = 16'h0000;

      case (state_q)
         IDLE: begin
            if (start) state_d = INIT_WR;
         end
         INIT_WR: begin
            chipselect   = 1'b1;
            write_n      = 1'b0;
            address      = ADDR_CTRL;
            writedata    = {12'h000, CTRL_INIT};
            tick_count_d = '0;
            running_d    = 1'b1;
            state_d      = RUN;
         end
         RUN: begin
            // Stopping wins over a simultaneous timeout.
            if (stop_pend_q || stop_req) state_d = STOP_WR;
            else if (irq)                state_d = RD_STAT;
         end
         RD_STAT: begin
            chipselect = 1'b1;
            address    = ADDR_STATUS;
            if (stop_req) stop_pend_d = 1'b1;
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (stop_req) stop_pend_d = 1'b1;
            if (readdata[0]) begin
               state_d = CLR_WR;
            end else begin
               err_spurious_d = 1'b1;
               state_d        = RUN;
            end
         end
         CLR_WR: begin
            chipselect   = 1'b1;
            write_n      = 1'b0;
            address      = ADDR_STATUS;
            writedata    = 16'h0000;
            if (stop_req) stop_pend_d = 1'b1;
            tick_pulse_d = 1'b1;
            tick_count_d = tick_count_q + {{(TICK_W-1){1'b0}}, 1'b1};
            state_d      = RUN;
         end
         STOP_WR: begin
            chipselect  = 1'b1;
            write_n     = 1'b0;
            address     = ADDR_CTRL;
            writedata   = CTRL_STOP;
            running_d   = 1'b0;
            stop_pend_d = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and status registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         running_q      <= 1'b0;
         stop_pend_q    <= 1'b0;
         tick_pulse_q   <= 1'b0;
         err_spurious_q <= 1'b0;
         tick_count_q   <= '0;
      end else begin
         state_q        <= state_d;
         running_q      <= running_d;
         stop_pend_q    <= stop_pend_d;
         tick_pulse_q   <= tick_pulse_d;
         err_spurious_q <= err_spurious_d;
         tick_count_q   <= tick_count_d;
      end
   end

   assign running      = running_q;
   assign tick_pulse   = tick_pulse_q;
   assign tick_count   = tick_count_q;
   assign err_spurious = err_spurious_q;

endmodule

// File: tb/tb_palt_nios_timer_host.sv
// tb/tb_palt_nios_timer_host.sv - directed self-checking bench for palt_nios_timer_host
module tb_palt_nios_timer_host;

   logic        clk = 1'b0;
   logic        reset, start, stop_req, irq;
   logic [15:0] readdata;
   logic [2:0]  address;
   logic        chipselect, write_n, running, tick_pulse, err_spurious;
   logic [15:0] writedata;
   logic [3:0]  tick_count;

   int checks = 0;
   int failures = 0;

   palt_nios_timer_host #(.TICK_W(4), .CTRL_INIT(4'b0111)) dut (
      .clk(clk), .reset(reset), .start(start), .stop_req(stop_req), .irq(irq),
      .readdata(readdata), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .running(running),
      .tick_pulse(tick_pulse), .tick_count(tick_count), .err_spurious(err_spurious)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_bus(input string tag, input logic cs, input logic wn,
                            input logic [2:0] ad, input logic [15:0] wd);
      check({tag, "_cs"}, chipselect, cs);
      check({tag, "_wn"}, write_n, wn);
      check({tag, "_addr"}, address, ad);
      check({tag, "_wd"}, writedata, wd);
   endtask

   // Full valid-timeout service from RUN; returns in the cycle after CLR_WR.
   task automatic service();
      irq = 1'b1; readdata = 16'h0001;
      step();
      irq = 1'b0;
      step(); step(); step();
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stop_req = 1'b0; irq = 1'b0; readdata = 16'h0000;
      step(); step();
      check_bus("rst", 1'b0, 1'b1, 3'd0, 16'h0000);
      check("rst_running", running, 1'b0);
      check("rst_count", tick_count, 4'd0);
      check("rst_pulse", tick_pulse, 1'b0);
      reset = 1'b0;

      // stop in IDLE is ignored
      stop_req = 1'b1; step(); stop_req = 1'b0; step();
      check_bus("idle_stop", 1'b0, 1'b1, 3'd0, 16'h0000);

      // start -> control write
      start = 1'b1; step(); start = 1'b0;
      check_bus("init", 1'b1, 1'b0, 3'd1, 16'h0007);
      step();
      check_bus("run0", 1'b0, 1'b1, 3'd0, 16'h0000);
      check("run0_running", running, 1'b1);
      check("run0_count", tick_count, 4'd0);

      // start ignored in RUN
      start = 1'b1; step(); start = 1'b0;
      check("run_start_cs", chipselect, 1'b0);

      // valid timeout
      irq = 1'b1; readdata = 16'h0003; step(); irq = 1'b0;
      check_bus("rdstat", 1'b1, 1'b1, 3'd0, 16'h0000);
      step();
      check("rdwait_cs", chipselect, 1'b0);
      step();
      check_bus("clr", 1'b1, 1'b0, 3'd0, 16'h0000);
      step();
      check("tick1_pulse", tick_pulse, 1'b1);
      check("tick1_count", tick_count, 4'd1);
      check("tick1_cs", chipselect, 1'b0);
      step();
      check("tick1_pulse_off", tick_pulse, 1'b0);

      // spurious timeout
      irq = 1'b1; readdata = 16'h0002; step(); irq = 1'b0;
      check("sp_rdstat_cs", chipselect, 1'b1);
      step(); step();
      check("sp_err", err_spurious, 1'b1);
      check("sp_cs", chipselect, 1'b0);
      check("sp_count", tick_count, 4'd1);
      step();
      check("sp_err_off", err_spurious, 1'b0);
      check("sp_no_write", chipselect, 1'b0);

      // stop arriving in RD_WAIT completes the clear first
      irq = 1'b1; readdata = 16'h0001; step(); irq = 1'b0;
      step();
      stop_req = 1'b1; step(); stop_req = 1'b0;
      check_bus("stp_clr", 1'b1, 1'b0, 3'd0, 16'h0000);
      step();
      check("stp_pulse", tick_pulse, 1'b1);
      check("stp_count", tick_count, 4'd2);
      step();
      check_bus("stp_wr", 1'b1, 1'b0, 3'd1, 16'h0008);
      step();
      check("stp_running", running, 1'b0);
      check("stp_idle_cs", chipselect, 1'b0);
      step();
      check("idle_hold_count", tick_count, 4'd2);

      // stop has priority over irq in RUN
      start = 1'b1; step(); start = 1'b0; step();
      check("restart_count", tick_count, 4'd0);
      irq = 1'b1; stop_req = 1'b1; step(); irq = 1'b0; stop_req = 1'b0;
      check_bus("prio_stop", 1'b1, 1'b0, 3'd1, 16'h0008);
      step();

      // wrap from all-ones
      start = 1'b1; step(); start = 1'b0; step();
      for (int i = 0; i < 15; i++) service();
      check("pre_wrap_count", tick_count, 4'hF);
      service();
      check("wrap_count", tick_count, 4'h0);
      check("wrap_pulse", tick_pulse, 1'b1);

      // reset during CLR_WR aborts
      irq = 1'b1; readdata = 16'h0001; step(); irq = 1'b0;
      step(); step();
      check("pre_rst_clr_cs", chipselect, 1'b1);
      reset = 1'b1; step();
      check_bus("abort", 1'b0, 1'b1, 3'd0, 16'h0000);
      check("abort_pulse", tick_pulse, 1'b0);
      check("abort_running", running, 1'b0);
      reset = 1'b0; step();
      check("abort_idle_cs", chipselect, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/palt_nios_timer_host.md
PALT_NIOS_TIMER_HOST -- requirements
Module: palt_nios_timer_host

Interface
REQ-001 The module SHALL have parameter TICK_W, default 32, giving the tick counter width.
REQ-002 The module SHALL have parameter CTRL_INIT, default 4'b0111 (START, CONT, ITO), giving the control word written at start.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port start, input, 1 bit: single-cycle request to program and run the timer.
REQ-006 The module SHALL have port stop_req, input, 1 bit: single-cycle request to stop the timer.
REQ-007 The module SHALL have port irq, input, 1 bit: the timer interrupt.
REQ-008 The module SHALL have port readdata, input, 16 bits: timer read data, valid one cycle after the read cycle.
REQ-009 The module SHALL have ports address (output, 3 bits), chipselect (output, 1 bit), write_n (output, 1 bit, active-low write) and writedata (output, 16 bits), forming an Avalon-MM master with no waitrequest.
REQ-010 The module SHALL have port running, output, 1 bit: timer programmed and not stopped.
REQ-011 The module SHALL have port tick_pulse, output, 1 bit: one-cycle pulse per serviced timeout.
REQ-012 The module SHALL have port tick_count, output, TICK_W bits: serviced-timeout count.
REQ-013 The module SHALL have port err_spurious, output, 1 bit: one-cycle pulse when irq is serviced but status TO=0.

Function
REQ-014 The FSM SHALL have states IDLE, INIT_WR, RUN, RD_STAT, RD_WAIT, CLR_WR and STOP_WR; every state except IDLE and RUN SHALL last exactly one cycle.
REQ-015 Outside bus states, outputs SHALL be: chipselect=0, write_n=1, address=0, writedata=0.
REQ-016 In IDLE, start=1 SHALL go to INIT_WR; start SHALL be ignored in all other states.
REQ-017 INIT_WR SHALL drive chipselect=1, write_n=0, address=1, writedata={12'h000,CTRL_INIT}, clear tick_count to 0, set running=1, then go to RUN.
REQ-018 In RUN, a pending or new stop SHALL go to STOP_WR, with priority over irq; otherwise irq=1 SHALL go to RD_STAT.
REQ-019 RD_STAT SHALL drive chipselect=1, write_n=1, address=0, then go to RD_WAIT with the bus idle.
REQ-020 In RD_WAIT, readdata[0]=1 SHALL go to CLR_WR; otherwise err_spurious SHALL pulse for one cycle and the FSM SHALL return to RUN.
REQ-021 CLR_WR SHALL drive chipselect=1, write_n=0, address=0, writedata=16'h0000, then return to RUN.
REQ-022 In the cycle after CLR_WR, tick_pulse SHALL be 1 and tick_count SHALL show its old value +1, wrapping from all-ones to 0.
REQ-023 stop_req SHALL be latched as pending when it arrives in RD_STAT, RD_WAIT or CLR_WR; any in-progress service sequence SHALL complete first.
REQ-024 stop_req in IDLE, INIT_WR or STOP_WR SHALL be ignored.
REQ-025 STOP_WR SHALL drive chipselect=1, write_n=0, address=1, writedata=16'h0008, clear running and the pending stop, then go to IDLE.
REQ-026 tick_count SHALL hold its value in IDLE.
REQ-027 The minimum irq-to-clear service time SHALL be 3 cycles (RD_STAT, RD_WAIT, CLR_WR).
REQ-028 A timeout arriving in the same cycle as CLR_WR is lost by the timer; the module SHALL NOT attempt to recover it.

Reset
REQ-029 While reset=1 at a clock edge, the FSM SHALL enter IDLE.
REQ-030 While reset=1 at a clock edge, the module SHALL set chipselect=0, write_n=1, address=0, writedata=0, running=0, tick_pulse=0, err_spurious=0, tick_count=0 and clear the pending stop.
REQ-031 Reset asserted mid-sequence (any state) SHALL abort that sequence with no further bus cycle.

Verification
REQ-032 start pulse -> one write to address 1 with data 16'h0007 on the next cycle; running=1 thereafter.
REQ-033 irq raised in RUN with readdata=16'h0003 on the following cycle -> read address 0, then write 16'h0000 to address 0, then tick_pulse=1 and tick_count=1.
REQ-034 irq raised with readdata=16'h0002 -> err_spurious pulses, no write is issued, tick_count is unchanged, FSM returns to RUN.
REQ-035 stop_req in RD_WAIT -> clear write completes, then write 16'h0008 to address 1, running=0.
REQ-036 Preload tick_count to all-ones (TICK_W=4, 15 ticks), service one more -> tick_count=0 with tick_pulse=1.
REQ-037 Reset asserted in CLR_WR -> next cycle chipselect=0, tick_pulse=0, running=0, FSM in IDLE.
